// File: rtl/hdu_sb.sv
// hdu_sb: scoreboard-based hazard detection unit.
//
// Tracks destination registers in flight through a shadow EXE/MA pipeline and
// long-latency mul/div writebacks in a per-register pending scoreboard. The
// stall/flush outputs of the hazard controller are fed back so the shadow
// stages stay aligned with the real pipeline.
//
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   id_valid                   valid instruction in ID
//   id_rs1_en/id_rs1           ID source 1 read enable / index
//   id_rs2_en/id_rs2           ID source 2 read enable / index
//   id_rd_en/id_rd             ID destination write enable / index
//   id_is_load, id_is_md       ID instruction class
//   {id,exe,ma}_{stall,flush}  controller outputs fed back
//   md_done/md_done_rd         mul/div writeback this cycle and its rd
//   md_kill                    abort every mul/div in flight
//   id_hazard                  ID must hold (load-use, scoreboard RAW/WAW)
//   exe_hazard                 EXE must hold (mul/div unit full)
//   sb_pending                 current scoreboard mask (debug)
//
// Optional feature (macro HDU_PERF_CNT_EN): perf_lu_cnt, perf_sb_cnt and
// perf_sh_cnt count cycles of load-use hazard, scoreboard hazard and
// exe_hazard. They wrap at 2^32 and reset to 0.

module hdu_sb #(
  parameter int unsigned XLEN_RF            = 32,
  parameter int unsigned MD_MAX_OUTSTANDING = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               id_valid,
  input  logic               id_rs1_en,
  input  logic [4:0]         id_rs1,
  input  logic               id_rs2_en,
  input  logic [4:0]         id_rs2,
  input  logic               id_rd_en,
  input  logic [4:0]         id_rd,
  input  logic               id_is_load,
  input  logic               id_is_md,
  input  logic               id_stall,
  input  logic               id_flush,
  input  logic               exe_stall,
  input  logic               exe_flush,
  input  logic               ma_stall,
  input  logic               ma_flush,
  input  logic               md_done,
  input  logic [4:0]         md_done_rd,
  input  logic               md_kill,
  output logic               id_hazard,
  output logic               exe_hazard,
`ifdef HDU_PERF_CNT_EN
  output logic [31:0]        perf_lu_cnt,
  output logic [31:0]        perf_sb_cnt,
  output logic [31:0]        perf_sh_cnt,
`endif
  output logic [XLEN_RF-1:0] sb_pending
);

  localparam logic [1:0] MdMax = 2'(MD_MAX_OUTSTANDING);

  typedef struct packed {
    logic       v;
    logic       rd_en;
    logic [4:0] rd;
    logic       is_load;
    logic       is_md;
  } stage_t;

  stage_t             exe_q, exe_d, ma_q, ma_d;
  logic [XLEN_RF-1:0] pend_q, pend_d;
  logic [XLEN_RF-1:0] set_vec, clr_vec, pend_vis;
  logic [1:0]         cnt_q, cnt_d;
  logic               md_set, md_clr;
  logic               lu_haz, sb_haz;

  // Shadow pipeline next state.
  always_comb begin
    exe_d = exe_q;
    if (exe_stall) begin
      if (exe_flush) exe_d.v = 1'b0;
    end else begin
      exe_d.v       = id_valid & ~id_flush & ~id_stall;
      exe_d.rd_en   = id_rd_en;
      exe_d.rd      = id_rd;
      exe_d.is_load = id_is_load;
      exe_d.is_md   = id_is_md;
    end

    ma_d = ma_q;
    if (!ma_stall) begin
      ma_d   = exe_q;
      ma_d.v = exe_q.v & ~exe_stall & ~exe_flush;
    end
    if (ma_flush) ma_d.v = 1'b0;
  end

  // A mul/div is recorded when it actually leaves EXE; x0 is never tracked.
  assign md_set  = exe_q.v & exe_q.is_md & exe_q.rd_en & (exe_q.rd != 5'd0) &
                   ~exe_stall & ~exe_flush;
  // A completion with nothing outstanding is spurious and ignored entirely.
  assign md_clr  = md_done & (cnt_q != 2'd0);
  assign set_vec = md_set ? (XLEN_RF'(1) << exe_q.rd) : '0;
  assign clr_vec = md_clr ? (XLEN_RF'(1) << md_done_rd) : '0;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (md_kill) begin
      pend_d = '0;
      cnt_d  = 2'd0;
    end else begin
      // Set after clear so a same-index set/clear leaves the bit pending.
      pend_d    = (pend_q & ~clr_vec) | set_vec;
      pend_d[0] = 1'b0;
      if (md_set && !md_clr) begin
        if (cnt_q != MdMax) cnt_d = cnt_q + 2'd1;
      end else if (!md_set && md_clr) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      exe_q  <= '0;
      ma_q   <= '0;
      pend_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      exe_q  <= exe_d;
      ma_q   <= ma_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Completing writeback is bypassed: its index no longer blocks ID.
  assign pend_vis = pend_q & ~clr_vec;

  assign lu_haz = id_valid & exe_q.v & exe_q.is_load & exe_q.rd_en & (exe_q.rd != 5'd0) &
                  ((id_rs1_en & (id_rs1 == exe_q.rd)) | (id_rs2_en & (id_rs2 == exe_q.rd)));

  assign sb_haz = id_valid &
                  ((id_rs1_en & (id_rs1 != 5'd0) & pend_vis[id_rs1]) |
                   (id_rs2_en & (id_rs2 != 5'd0) & pend_vis[id_rs2]) |
                   (id_rd_en  & (id_rd  != 5'd0) & pend_vis[id_rd]));

  assign id_hazard  = lu_haz | sb_haz;
  assign exe_hazard = exe_q.v & exe_q.is_md & (cnt_q == MdMax) & ~md_done;
  assign sb_pending = pend_q;

`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_lu_cnt <= '0;
      perf_sb_cnt <= '0;
      perf_sh_cnt <= '0;
    end else begin
      if (lu_haz)     perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (sb_haz)     perf_sb_cnt <= perf_sb_cnt + 32'd1;
      if (exe_hazard) perf_sh_cnt <= perf_sh_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hdu_sb.md
Name: hdu_sb

Overview:
- Scoreboard-based hazard detection unit. Produces the `id_hazard` / `exe_hazard` requests that the hazard/flush controller turns into per-stage stall and flush.
- Tracks destination registers in flight in a shadow EXE/MA pipeline, plus long-latency mul/div writebacks in a 32-entry pending scoreboard.
- Receives the controller's stall/flush outputs back, so its shadow state stays aligned with the real pipeline.

Parameters:
- `XLEN_RF`, 32, number of architectural integer registers (scoreboard depth; index width is log2).
- `MD_MAX_OUTSTANDING`, 1, mul/div operations in flight at once (1 or 2).

Ports:
- `clk` input 1 core clock
- `rstn` input 1 synchronous active-low reset
- `id_valid` input 1 valid instruction in ID
- `id_rs1_en` input 1 ID reads rs1
- `id_rs1` input 5 rs1 index
- `id_rs2_en` input 1 ID reads rs2
- `id_rs2` input 5 rs2 index
- `id_rd_en` input 1 ID writes rd
- `id_rd` input 5 rd index
- `id_is_load` input 1 ID instruction is a load
- `id_is_md` input 1 ID instruction is mul/div
- `id_stall` input 1 from hazard controller
- `id_flush` input 1 from hazard controller
- `exe_stall` input 1 from hazard controller
- `exe_flush` input 1 from hazard controller
- `ma_stall` input 1 from hazard controller
- `ma_flush` input 1 from hazard controller
- `md_done` input 1 mul/div result written back this cycle
- `md_done_rd` input 5 rd of completing mul/div
- `md_kill` input 1 abort all mul/div in flight (fault flush)
- `id_hazard` output 1 ID must hold (load-use or scoreboard RAW/WAW)
- `exe_hazard` output 1 EXE must hold (mul/div unit full)
- `sb_pending` output 32 current scoreboard mask (debug)

Behaviour:
- Clocking and reset:
  - All state updates on posedge `clk`.
  - `rstn`=0 synchronously clears shadow valid bits, `sb_pending`=0 and the outstanding count=0.
  - Outputs are combinational from state and ID inputs, so `id_hazard`=0 and `exe_hazard`=0 whenever state is reset and `id_valid`=0.
- Shadow pipeline, per stage: `{v, rd_en, rd, is_load, is_md}`.
  - ID→EXE:
    - If `exe_stall`, EXE holds (`exe_flush` with stall inserts a bubble: `v`←0).
    - Else EXE←ID fields with `v`=`id_valid` & ~`id_flush` & ~`id_stall`.
  - EXE→MA: MA←EXE fields when ~`ma_stall`; `v` additionally gated by ~`exe_stall` & ~`exe_flush`. `ma_flush` clears MA `v`.
- Load-use hazard:
  - Condition: `id_valid` & EXE.v & EXE.is_load & EXE.rd_en & EXE.rd≠0.
  - Asserts `id_hazard` when (`id_rs1_en` & `id_rs1`==EXE.rd) | (`id_rs2_en` & `id_rs2`==EXE.rd).
- Scoreboard:
  - Set `sb_pending`[EXE.rd] when EXE.v & EXE.is_md & EXE.rd_en & EXE.rd≠0 & ~`exe_stall` & ~`exe_flush`; outstanding count +1.
  - `md_done` clears `sb_pending`[`md_done_rd`]; count −1.
  - Set and clear of the same index in the same cycle: set wins.
  - Count saturates and never underflows; `md_done` with count=0 is ignored.
  - `md_kill` clears the whole mask and the count; it has priority over a simultaneous set.
- Scoreboard hazard: `id_hazard` also asserts when `id_valid` and any of the following is pending in `sb_pending`:
  - `id_rs1` (RAW, if enabled);
  - `id_rs2` (RAW, if enabled);
  - `id_rd` (WAW, if `id_rd_en`).
- Register x0: index 0 is never marked pending and never causes a hazard.
- `exe_hazard`: EXE.v & EXE.is_md & count==`MD_MAX_OUTSTANDING` & ~`md_done`.
- Latency:
  - Hazards are visible the same cycle as the ID/EXE contents.
  - A completing `md_done` releases a dependent ID instruction in that same cycle (bypass: the clearing index is excluded from the compare).

Optional Feature:
- Macro `HDU_PERF_CNT_EN` adds outputs `perf_lu_cnt` [31:0], `perf_sb_cnt` [31:0] and `perf_sh_cnt` [31:0]. They count cycles of load-use hazard, scoreboard hazard and `exe_hazard` respectively.
- Counters wrap at 2^32 and reset to 0.
- Without the macro these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Load x5 in EXE; ID add reads rs1=x5 → `id_hazard`=1 for exactly one cycle. With ID stalled and EXE bubbled, the next cycle `id_hazard`=0.
- Mul rd=x7 leaves EXE → `sb_pending`=0x00000080. ID reads x7 → `id_hazard`=1 until the cycle `md_done`=1 with `md_done_rd`=7, where it drops to 0 and `sb_pending`=0.
- Mul rd=x0 issued → `sb_pending` stays 0 and no hazard on an x0 read.
- With `MD_MAX_OUTSTANDING`=1: second div in EXE while first is pending → `exe_hazard`=1. Raising `md_done` → `exe_hazard`=0 the same cycle, and the second div's rd gets set.
- Div rd=x9 pending; ID writes x9 (WAW) → `id_hazard`=1. Assert `md_kill` → `sb_pending`=0 and `id_hazard`=0 next cycle.
- Assert `rstn`=0 mid-operation with `sb_pending`=0x00000300 → after one clock `sb_pending`=0, shadow stages invalid, and both hazards 0.
